// File: rtl/dma_pkg.sv
// Shared constants for the DMA read master: FSM encodings, command field
// layout and word size.
package dma_pkg;

  localparam logic [2:0] RD_IDLE  = 3'd0;
  localparam logic [2:0] RD_CHK   = 3'd1;
  localparam logic [2:0] RD_SPACE = 3'd2;
  localparam logic [2:0] RD_REQ   = 3'd3;
  localparam logic [2:0] RD_DATA  = 3'd4;
  localparam logic [2:0] RD_DONE  = 3'd5;

  // Command word layout: {addr[31:0], bytes[15:0]}
  localparam int CMD_BYTES_LSB = 0;
  localparam int CMD_BYTES_W   = 16;
  localparam int CMD_ADDR_LSB  = 16;
  localparam int CMD_ADDR_W    = 32;
  localparam int CMD_W         = CMD_ADDR_W + CMD_BYTES_W;

  localparam int WORD_BYTES    = 4;
  localparam int WORDS_W       = 17;

  function automatic logic [WORDS_W-1:0] bytes_to_words(input logic [CMD_BYTES_W-1:0] bytes);
    logic [WORDS_W-1:0] sum;
    sum = {1'b0, bytes} + WORDS_W'(WORD_BYTES - 1);
    return sum >> 2;
  endfunction

endpackage

// File: rtl/dma_rd_cmd_fifo.sv
// Show-ahead register FIFO holding pending read commands; a push into a full
// FIFO is dropped and flagged unless a pop frees a slot in the same cycle.
module dma_rd_cmd_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  assign do_pop     = pop_i & (count_q != '0);
  assign do_push    = push_i & (~full_q | do_pop);
  assign overflow_o = push_i & full_q & ~do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
    full_d = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dma_rd_master.sv
// DMA read master: queues read commands and runs each one as a series of
// single-outstanding Avalon-MM burst reads streamed to the data buffer.
//
// state    | meaning
// IDLE     | waiting for a queued command; pops and latches it
// CHK      | zero-length commands skip straight to DONE
// SPACE    | waits for the data buffer to have room for a full burst
// REQ      | read request held until the slave accepts it
// DATA     | collecting beats of the outstanding burst
// DONE     | one-cycle completion, then back to IDLE
module dma_rd_master
  import dma_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int MAX_BURST = 8,
  parameter int BC_W      = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dma_rd_fifo_command_rq_i,
  input  logic [31:0]     dma_rd_addr_i,
  input  logic [15:0]     dma_rd_bytes_to_transfer_i,
  output logic            dma_rd_fifo_full_o,
  output logic [31:0]     avm_address_o,
  output logic            avm_read_o,
  output logic [BC_W-1:0] avm_burstcount_o,
  input  logic            avm_waitrequest_i,
  input  logic [31:0]     avm_readdata_i,
  input  logic            avm_readdatavalid_i,
  output logic [31:0]     dma_rd_data_o,
  output logic            dma_rd_data_valid_o,
  output logic            dma_rd_data_last_o,
  input  logic            dma_rd_data_almost_full_i,
  output logic            dma_rd_done_o,
  output logic            dma_rd_err_o
);

  logic [CMD_W-1:0]   fifo_din, fifo_dout;
  logic               fifo_empty, fifo_overflow, fifo_pop;
  logic [31:0]        cmd_addr;
  logic [15:0]        cmd_bytes;

  logic [2:0]         state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [WORDS_W-1:0] remain_q, remain_d;
  logic [BC_W-1:0]    burst_q, burst_d;
  logic [BC_W-1:0]    beat_q, beat_d;
  logic               unaligned;
  logic               beat_in;

  logic [31:0]        data_q;
  logic               valid_q, last_q, done_q, err_q;

  assign fifo_din = {dma_rd_addr_i, dma_rd_bytes_to_transfer_i};

  dma_rd_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (dma_rd_fifo_command_rq_i),
    .din_i      (fifo_din),
    .pop_i      (fifo_pop),
    .dout_o     (fifo_dout),
    .full_o     (dma_rd_fifo_full_o),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  assign cmd_addr  = fifo_dout[CMD_ADDR_LSB +: CMD_ADDR_W];
  assign cmd_bytes = fifo_dout[CMD_BYTES_LSB +: CMD_BYTES_W];

  // Beats arriving in any other state (e.g. left over from before a reset) are dropped.
  assign beat_in = avm_readdatavalid_i & (state_q == RD_DATA);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    fifo_pop  = 1'b0;
    unaligned = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_d    = {cmd_addr[31:2], 2'b00};
          remain_d  = bytes_to_words(cmd_bytes);
          unaligned = |cmd_addr[1:0];
          state_d   = RD_CHK;
        end
      end
      RD_CHK: begin
        state_d = (remain_q == '0) ? RD_DONE : RD_SPACE;
      end
      RD_SPACE: begin
        if (!dma_rd_data_almost_full_i) begin
          burst_d = (remain_q > WORDS_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(remain_q);
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest_i) begin
          beat_d  = burst_q;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (beat_in) begin
          beat_d   = beat_q - 1'b1;
          remain_d = remain_q - 1'b1;
          if (beat_q == BC_W'(1)) begin
            addr_d  = addr_q + (32'(burst_q) << 2);
            state_d = (remain_q == WORDS_W'(1)) ? RD_DONE : RD_SPACE;
          end
        end
      end
      RD_DONE: begin
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
    end
  end

  // Output stage: one cycle behind the Avalon return; done trails last by one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (beat_in) data_q <= avm_readdata_i;
      valid_q <= beat_in;
      last_q  <= beat_in & (remain_q == WORDS_W'(1));
      done_q  <= (state_q == RD_DONE);
      err_q   <= err_q | fifo_overflow | unaligned;
    end
  end

  assign avm_address_o       = addr_q;
  assign avm_read_o          = (state_q == RD_REQ);
  assign avm_burstcount_o    = burst_q;
  assign dma_rd_data_o       = data_q;
  assign dma_rd_data_valid_o = valid_q;
  assign dma_rd_data_last_o  = last_q;
  assign dma_rd_done_o       = done_q;
  assign dma_rd_err_o        = err_q;

endmodule

// File: tb/tb_dma_rd_master.sv
// Scoreboard bench for dma_rd_master: commands expand into expected bursts,
// words and completions; an Avalon slave model and an output monitor pop and compare.
module tb_dma_rd_master;

  localparam int CMD_DEPTH = 4;
  localparam int MAX_BURST = 8;
  localparam int BC_W      = 7;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            dma_rd_fifo_command_rq_i;
  logic [31:0]     dma_rd_addr_i;
  logic [15:0]     dma_rd_bytes_to_transfer_i;
  logic            dma_rd_fifo_full_o;
  logic [31:0]     avm_address_o;
  logic            avm_read_o;
  logic [BC_W-1:0] avm_burstcount_o;
  logic            avm_waitrequest_i;
  logic [31:0]     avm_readdata_i;
  logic            avm_readdatavalid_i;
  logic [31:0]     dma_rd_data_o;
  logic            dma_rd_data_valid_o;
  logic            dma_rd_data_last_o;
  logic            dma_rd_data_almost_full_i;
  logic            dma_rd_done_o;
  logic            dma_rd_err_o;

  dma_rd_master #(
    .CMD_DEPTH (CMD_DEPTH),
    .MAX_BURST (MAX_BURST),
    .BC_W      (BC_W)
  ) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .dma_rd_fifo_command_rq_i   (dma_rd_fifo_command_rq_i),
    .dma_rd_addr_i              (dma_rd_addr_i),
    .dma_rd_bytes_to_transfer_i (dma_rd_bytes_to_transfer_i),
    .dma_rd_fifo_full_o         (dma_rd_fifo_full_o),
    .avm_address_o              (avm_address_o),
    .avm_read_o                 (avm_read_o),
    .avm_burstcount_o           (avm_burstcount_o),
    .avm_waitrequest_i          (avm_waitrequest_i),
    .avm_readdata_i             (avm_readdata_i),
    .avm_readdatavalid_i        (avm_readdatavalid_i),
    .dma_rd_data_o              (dma_rd_data_o),
    .dma_rd_data_valid_o        (dma_rd_data_valid_o),
    .dma_rd_data_last_o         (dma_rd_data_last_o),
    .dma_rd_data_almost_full_i  (dma_rd_data_almost_full_i),
    .dma_rd_done_o              (dma_rd_done_o),
    .dma_rd_err_o               (dma_rd_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int bc; } burst_t;
  typedef struct { logic [31:0] d; logic last; } word_t;

  burst_t exp_burst[$];
  word_t  exp_data[$];
  bit     exp_done[$];
  bit     exp_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // slave / monitor controls and statistics
  bit          af_force = 1'b1;
  logic        af_val = 1'b0;
  bit          rand_wait = 1'b0;
  int          wait_cnt = 0;
  int          s_limit = -1;
  int          stale_cnt = 0;
  bit          t4_arm = 1'b0;
  bit          lat_arm = 1'b0;
  int          lat_push_cyc = 0;
  int          accepts = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;
  int          s_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E ^ (a << 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  // Reference model: expand a command into its bursts, words and completion.
  task automatic model_cmd(input logic [31:0] a, input logic [15:0] b);
    int          words;
    int          rem;
    int          n;
    logic [31:0] base;
    logic [31:0] p;
    words = (int'(b) + 3) / 4;
    base  = a & 32'hFFFF_FFFC;
    if (a[1:0] != 2'b00) exp_err = 1'b1;
    p   = base;
    rem = words;
    while (rem > 0) begin
      n = (rem > MAX_BURST) ? MAX_BURST : rem;
      exp_burst.push_back('{addr: p, bc: n});
      p   = p + 32'(4 * n);
      rem = rem - n;
    end
    for (int i = 0; i < words; i++)
      exp_data.push_back('{d: hashw(base + 32'(4 * i)), last: (i == words - 1)});
    exp_done.push_back(words == 0);
  endtask

  task automatic push_cmd(input logic [31:0] a, input logic [15:0] b, input bit accept);
    dma_rd_fifo_command_rq_i   = 1'b1;
    dma_rd_addr_i              = a;
    dma_rd_bytes_to_transfer_i = b;
    lat_push_cyc = cyc + 1;
    if (accept) model_cmd(a, b);
    @(negedge clk);
    dma_rd_fifo_command_rq_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_burst.size() != 0 || exp_data.size() != 0 || exp_done.size() != 0 || s_left != 0)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_event({tag, "_drain_timeout"});
    repeat (3) @(negedge clk);
  endtask

  // Avalon slave model: accepts requests, checks them against the scoreboard, returns beats.
  initial begin : slave
    logic [31:0] s_addr;
    logic [31:0] h_addr;
    int          h_bc;
    bit          s_hold;
    bit          prev_read;
    int          req_cycles;
    burst_t      b;
    s_addr = '0; h_addr = '0; h_bc = 0; s_hold = 0; prev_read = 0; req_cycles = 0;
    avm_waitrequest_i = 1'b0;
    avm_readdata_i = '0;
    avm_readdatavalid_i = 1'b0;
    dma_rd_data_almost_full_i = 1'b0;
    forever begin
      @(negedge clk);
      avm_readdatavalid_i = 1'b0;
      dma_rd_data_almost_full_i = af_force ? af_val : ($urandom_range(0, 3) == 0);
      if (!reset_n) begin
        s_left = 0; s_hold = 0; prev_read = 0; req_cycles = 0;
        avm_waitrequest_i = 1'b0;
        continue;
      end
      if (stale_cnt > 0) begin
        avm_readdatavalid_i = 1'b1;
        avm_readdata_i = 32'hDEAD_BEEF;
        stale_cnt--;
      end else if (s_left > 0 && s_limit != 0 && $urandom_range(0, 3) != 0) begin
        avm_readdatavalid_i = 1'b1;
        avm_readdata_i = hashw(s_addr);
        s_addr = s_addr + 32'd4;
        s_left--;
        if (s_limit > 0) s_limit--;
      end
      if (avm_read_o) begin
        if (lat_arm && !prev_read) begin
          chk("req_latency", 64'(cyc - lat_push_cyc), 64'd3);
          lat_arm = 0;
        end
        if (s_hold) begin
          chk("hold_addr", 64'(avm_address_o), 64'(h_addr));
          chk("hold_bc", 64'(avm_burstcount_o), 64'(h_bc));
        end
        req_cycles++;
        if (wait_cnt > 0 || (rand_wait && $urandom_range(0, 3) == 0)) begin
          avm_waitrequest_i = 1'b1;
          if (wait_cnt > 0) wait_cnt--;
          if (!s_hold) begin
            h_addr = avm_address_o;
            h_bc   = int'(avm_burstcount_o);
          end
          s_hold = 1;
        end else begin
          avm_waitrequest_i = 1'b0;
          s_hold = 0;
          if (t4_arm) begin
            chk("t4_req_cycles", 64'(req_cycles), 64'd6);
            t4_arm = 0;
          end
          req_cycles = 0;
          if (s_left != 0) fail_event("burst_overlap");
          if (exp_burst.size() == 0) begin
            fail_event("burst_unexpected");
          end else begin
            b = exp_burst.pop_front();
            chk("burst_addr", 64'(avm_address_o), 64'(b.addr));
            chk("burst_bc", 64'(avm_burstcount_o), 64'(b.bc));
          end
          s_addr = avm_address_o;
          s_left = int'(avm_burstcount_o);
          accepts++;
        end
      end else begin
        avm_waitrequest_i = 1'($urandom_range(0, 1));
        s_hold = 0;
        req_cycles = 0;
      end
      prev_read = avm_read_o;
    end
  end

  // Output monitor: data words, last flag and completion pulses.
  initial begin : monitor
    bit    prev_last;
    word_t w;
    bit    z;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_last = 0;
        continue;
      end
      if (dma_rd_data_valid_o) begin
        beats_seen++;
        if (exp_data.size() == 0) begin
          fail_event("data_unexpected");
        end else begin
          w = exp_data.pop_front();
          chk("data", 64'(dma_rd_data_o), 64'(w.d));
          chk("last", 64'(dma_rd_data_last_o), 64'(w.last));
        end
      end else if (dma_rd_data_last_o) begin
        fail_event("last_without_valid");
      end
      if (prev_last) chk("done_after_last", 64'(dma_rd_done_o), 64'd1);
      if (dma_rd_done_o) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          fail_event("done_unexpected");
        end else begin
          z = exp_done.pop_front();
          if (!z) chk("done_follows_last", 64'(prev_last), 64'd1);
        end
      end
      prev_last = dma_rd_data_last_o;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base_acc;
    int base_beats;
    int base_done;
    int n;
    reset_n = 1'b0;
    dma_rd_fifo_command_rq_i = 1'b0;
    dma_rd_addr_i = '0;
    dma_rd_bytes_to_transfer_i = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_full", 64'(dma_rd_fifo_full_o), 64'd0);
    chk("rst_read", 64'(avm_read_o), 64'd0);
    chk("rst_addr", 64'(avm_address_o), 64'd0);
    chk("rst_bc", 64'(avm_burstcount_o), 64'd0);
    chk("rst_valid", 64'(dma_rd_data_valid_o), 64'd0);
    chk("rst_done", 64'(dma_rd_done_o), 64'd0);
    chk("rst_err", 64'(dma_rd_err_o), 64'd0);

    // two full bursts, plus the push-to-request latency
    base_acc = accepts; base_beats = beats_seen;
    lat_arm = 1;
    push_cmd(32'h0000_1000, 16'd64, 1);
    wait_drain(500, "t1");
    chk("t1_accepts", 64'(accepts - base_acc), 64'd2);
    chk("t1_beats", 64'(beats_seen - base_beats), 64'd16);
    chk("t1_err", 64'(dma_rd_err_o), 64'd0);

    // partial final word rounds up
    push_cmd(32'h0000_2000, 16'd10, 1);
    wait_drain(300, "t2");

    // zero-length command
    base_acc = accepts; base_done = done_cnt;
    push_cmd(32'h0000_3000, 16'd0, 1);
    wait_drain(100, "t3");
    chk("t3_no_read", 64'(accepts - base_acc), 64'd0);
    chk("t3_done", 64'(done_cnt - base_done), 64'd1);
    chk("t3_full", 64'(dma_rd_fifo_full_o), 64'd0);

    // slave stalls the first request for 5 cycles
    base_acc = accepts;
    wait_cnt = 5; t4_arm = 1;
    push_cmd(32'h0000_4000, 16'd20, 1);
    wait_drain(300, "t4");
    chk("t4_accepts", 64'(accepts - base_acc), 64'd1);
    chk("t4_armed_consumed", 64'(t4_arm), 64'd0);

    // fill the FIFO behind a command parked in SPACE, then overflow it
    af_val = 1'b1;
    push_cmd(32'h0000_5000, 16'd16, 1);
    repeat (4) @(negedge clk);
    push_cmd(32'h0000_5100, 16'd8, 1);
    chk("t5_full_1", 64'(dma_rd_fifo_full_o), 64'd0);
    push_cmd(32'h0000_5200, 16'd12, 1);
    chk("t5_full_2", 64'(dma_rd_fifo_full_o), 64'd0);
    push_cmd(32'h0000_5300, 16'd4, 1);
    chk("t5_full_3", 64'(dma_rd_fifo_full_o), 64'd0);
    push_cmd(32'h0000_5400, 16'd36, 1);
    chk("t5_full_4", 64'(dma_rd_fifo_full_o), 64'd1);
    push_cmd(32'h0000_5500, 16'd8, 0);
    exp_err = 1'b1;
    chk("t5_err", 64'(dma_rd_err_o), 64'd1);
    chk("t5_full_hold", 64'(dma_rd_fifo_full_o), 64'd1);
    af_val = 1'b0;
    wait_drain(1000, "t5");
    chk("t5_full_clear", 64'(dma_rd_fifo_full_o), 64'd0);

    // reset with 3 beats still owed, then stale returns
    s_limit = 5;
    base_beats = beats_seen;
    push_cmd(32'h0000_6000, 16'd32, 1);
    n = 0;
    while (beats_seen - base_beats < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_event("t6_beats_timeout");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    exp_burst.delete();
    exp_data.delete();
    exp_done.delete();
    exp_err = 1'b0;
    s_limit = -1;
    @(negedge clk);
    reset_n = 1'b1;
    base_beats = beats_seen;
    stale_cnt = 3;
    repeat (6) @(negedge clk);
    chk("t6_no_beats", 64'(beats_seen - base_beats), 64'd0);
    chk("t6_valid", 64'(dma_rd_data_valid_o), 64'd0);
    chk("t6_data", 64'(dma_rd_data_o), 64'd0);
    chk("t6_read", 64'(avm_read_o), 64'd0);
    chk("t6_addr", 64'(avm_address_o), 64'd0);
    chk("t6_err", 64'(dma_rd_err_o), 64'd0);
    push_cmd(32'h0000_6100, 16'd12, 1);
    wait_drain(300, "t6");

    // unaligned source is rounded down and flagged
    push_cmd(32'h0000_7002, 16'd8, 1);
    wait_drain(300, "t7");
    chk("t7_err", 64'(dma_rd_err_o), 64'(exp_err));

    // address wraps past 2^32
    push_cmd(32'hFFFF_FFF0, 16'd40, 1);
    wait_drain(300, "t8");

    // randomized traffic with random stalls and buffer backpressure
    af_force = 0; rand_wait = 1;
    for (int i = 0; i < 25; i++) begin
      n = 0;
      while (dma_rd_fifo_full_o && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) fail_event("rand_full_timeout");
      push_cmd({$urandom_range(0, 32'hFFFF) , 14'($urandom), ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00},
               16'($urandom_range(0, 90)), 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_drain(20000, "rand");
    chk("rand_err", 64'(dma_rd_err_o), 64'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
